full_fn_csr_master: RTL

// - Avalon-MM master that drives the full_fn CSR slave: it programs the element count, starts the job, then polls progress.
// - Sits between the host-side sequencer and the accelerator's 4x32-bit CSR port (0 ctrl, 1 count, 2 status, 3 progress).
// - Each job gets one done pulse. The job ends on completion, timeout or abort, and the master clears ctrl when the job ends.

---
 rtl/full_fn_csr_master.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/full_fn_csr_master.sv
// full_fn_csr_master: Avalon-MM master that runs one full_fn accelerator job.
// It writes the element count and the start bit, polls progress until it
// reaches the count (or a poll limit is hit, or the host aborts), then clears
// ctrl and reports a single done pulse.
//
// Ports:
//   clk, aclr          clock (posedge) and asynchronous active-high reset
//   start, n_elements  job request (sampled only when idle) and element count
//   abort              level request to end the running job early
//   busy               high from accepted start until done
//   done, timeout      1-cycle end-of-job pulse; timeout marks a poll-limit end
//   progress           last value read from the progress CSR
//   m_address, m_read, m_write, m_writedata, m_readdata, m_waitrequest
//                      Avalon-MM master port to the 4-word CSR block
module full_fn_csr_master #(
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned POLL_INTERVAL = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024,
  parameter logic [31:0] CTRL_START    = 32'h4
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  input  logic [31:0] n_elements,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] progress,
  output logic [1:0]  m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 2;
  localparam int unsigned PCW_MIN = 11;
  localparam int unsigned PCW_REQ = $clog2(TIMEOUT_POLLS + 1);
  localparam int unsigned PCW     = (PCW_REQ > PCW_MIN) ? PCW_REQ : PCW_MIN;
  localparam int unsigned LCW     = $clog2(READ_LATENCY + 1);
  localparam int unsigned GCW     = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  localparam logic [AW-1:0]  A_CTRL     = AW'(0);
  localparam logic [AW-1:0]  A_COUNT    = AW'(1);
  localparam logic [AW-1:0]  A_PROG     = AW'(3);
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(TIMEOUT_POLLS);
  localparam logic [LCW-1:0] LAT_LAST   = LCW'(READ_LATENCY - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_COUNT,
    WR_START,
    POLL_RD,
    POLL_WAIT,
    POLL_GAP,
    WR_STOP,
    DONE
  } state_t;

  state_t         state;
  logic [DW-1:0]  n_q;
  logic [PCW-1:0] poll_cnt;
  logic [LCW-1:0] lat_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           to_flag;
  logic           abort_q;

  logic [PCW-1:0] poll_next_c;
  logic           abort_seen_c;
  logic           rd_complete_c;

  // Poll limit ends the job before the counter can exceed TIMEOUT_POLLS.
  assign poll_next_c   = poll_cnt + PCW'(1);
  // A short abort pulse during a bus command is remembered until the command ends.
  assign abort_seen_c  = abort | abort_q;
  assign rd_complete_c = (m_readdata >= n_q);

  // Job sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      progress    <= '0;
      m_address   <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      n_q         <= '0;
      poll_cnt    <= '0;
      lat_cnt     <= '0;
      gap_cnt     <= '0;
      to_flag     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            n_q      <= n_elements;
            busy     <= 1'b1;
            poll_cnt <= '0;
            to_flag  <= 1'b0;
            abort_q  <= 1'b0;
            state    <= (n_elements == '0) ? DONE : WR_COUNT;
          end
        end

        // Count write is launched here; later commands are launched on the
        // transition into their state so they can run back to back.
        WR_COUNT: begin
          if (abort) abort_q <= 1'b1;
          if (!m_write) begin
            m_write     <= 1'b1;
            m_address   <= A_COUNT;
            m_writedata <= n_q;
          end else if (!m_waitrequest) begin
            m_address <= A_CTRL;
            if (abort_seen_c) begin
              m_writedata <= '0;
              state       <= WR_STOP;
            end else begin
              m_writedata <= CTRL_START;
              state       <= WR_START;
            end
          end
        end

        WR_START: begin
          if (abort) abort_q <= 1'b1;
          if (!m_write) begin
            m_write     <= 1'b1;
            m_address   <= A_CTRL;
            m_writedata <= CTRL_START;
          end else if (!m_waitrequest) begin
            if (abort_seen_c) begin
              m_address   <= A_CTRL;
              m_writedata <= '0;
              state       <= WR_STOP;
            end else begin
              m_write   <= 1'b0;
              m_read    <= 1'b1;
              m_address <= A_PROG;
              state     <= POLL_RD;
            end
          end
        end

        // An abort here still lets the read data come back and be captured.
        POLL_RD: begin
          if (abort) abort_q <= 1'b1;
          if (!m_read) begin
            m_read    <= 1'b1;
            m_address <= A_PROG;
          end else if (!m_waitrequest) begin
            m_read  <= 1'b0;
            lat_cnt <= '0;
            state   <= POLL_WAIT;
          end
        end

        // Completion wins over abort and timeout; abort wins over timeout.
        POLL_WAIT: begin
          if (abort) abort_q <= 1'b1;
          if (lat_cnt == LAT_LAST) begin
            progress <= m_readdata;
            poll_cnt <= poll_next_c;
            if (rd_complete_c || abort_seen_c) begin
              m_write     <= 1'b1;
              m_address   <= A_CTRL;
              m_writedata <= '0;
              state       <= WR_STOP;
            end else if (poll_next_c == POLL_LIMIT) begin
              to_flag     <= 1'b1;
              m_write     <= 1'b1;
              m_address   <= A_CTRL;
              m_writedata <= '0;
              state       <= WR_STOP;
            end else begin
              gap_cnt <= '0;
              state   <= POLL_GAP;
            end
          end else begin
            lat_cnt <= lat_cnt + LCW'(1);
          end
        end

        POLL_GAP: begin
          if (abort_seen_c) begin
            m_write     <= 1'b1;
            m_address   <= A_CTRL;
            m_writedata <= '0;
            state       <= WR_STOP;
          end else if (gap_cnt == GAP_LAST) begin
            m_read    <= 1'b1;
            m_address <= A_PROG;
            state     <= POLL_RD;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end

        WR_STOP: begin
          if (!m_write) begin
            m_write     <= 1'b1;
            m_address   <= A_CTRL;
            m_writedata <= '0;
          end else if (!m_waitrequest) begin
            m_write <= 1'b0;
            state   <= DONE;
          end
        end

        DONE: begin
          done    <= 1'b1;
          timeout <= to_flag;
          busy    <= 1'b0;
          abort_q <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
